store_buffer: RTL

//  Posted-write FIFO between the core's load/store datapath and the data memory.
//  The core issues stores without waiting; the buffer drains them to the memory
//  one word per cycle, whenever the memory's single address port is not needed by a load.

---
 rtl/store_buffer.sv | 104 ++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO draining core stores to data memory around loads.
// Define STORE_BUFFER_FWD_EN to forward the youngest matching store instead of stalling the load.
module store_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [DATA_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_ready,
  input  logic                  ld_req,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_stall,
  output logic                  mem_WE,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD,
  output logic                  sb_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  push;
  logic                  drain;
  logic                  load_owns;
  logic                  hit;
`ifdef STORE_BUFFER_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_data;
`endif

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (addr_q[head_q + PTR_W'(i)] == ld_addr)) begin
        hit = ld_req;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = data_q[head_q + PTR_W'(i)];
`endif
      end
    end
  end

  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign sb_empty = (count_q == '0);

`ifdef STORE_BUFFER_FWD_EN
  assign ld_stall = 1'b0;
  assign ld_data  = hit ? fwd_data : mem_RD;
`else
  assign ld_stall = hit;
  assign ld_data  = mem_RD;
`endif

  // Single memory port: an unstalled load wins, otherwise the head entry drains.
  assign load_owns   = ld_req && !ld_stall;
  assign drain       = !sb_empty && !load_owns;
  assign push        = st_valid && st_ready;
  assign mem_WE      = drain;
  assign mem_address = drain ? addr_q[head_q] : ld_addr;
  assign mem_WD      = data_q[head_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (drain) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

endmodule
